vpi_var_model_bank: RTL

Parametrised VPI variable-model bank: a `CHANNELS` x `DEPTH` array of `WIDTH`-bit `public_flat_rw @(posedge clk)` registers driven by a fill/wait/check sequencer. The bank writes a known pattern, waits while an external VPI agent XORs every entry with `mask`, then verifies each entry cycle-by-cycle and reports a pass flag and mismatch count. It generalises the fixed-shape public-variable regression to arbitrary width, depth and channel count, and adds handshaked sequencing and self-checking.

---
 rtl/vpi_var_model_pkg.sv | 28 ++
 rtl/vpi_var_model_walker.sv | 55 +++++
 rtl/vpi_var_model_bank.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vpi_var_model_pkg.sv
// Shared types and helpers for the VPI variable-model bank: FSM state encoding,
// index-width helper and the fill pattern generator.
package vpi_var_model_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StWait,
    StCheck,
    StDone
  } state_e;

  // Raw pattern width; callers truncate to their entry width.
  localparam int unsigned PatW = 32;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [PatW-1:0] pattern(input int unsigned seed,
                                              input int unsigned depth,
                                              input int unsigned chan,
                                              input int unsigned idx);
    return PatW'(seed + chan * depth + idx);
  endfunction

endpackage

// File: rtl/vpi_var_model_walker.sv
// Channel/index walker: index-minor, channel-major traversal of the bank with
// synchronous clear, step and a last-entry flag.
module vpi_var_model_walker
  import vpi_var_model_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned ChanW   = idx_width(CHANNELS),
  localparam int unsigned IdxW    = idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             step_i,
  output logic [ChanW-1:0] chan_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             last_o
);

  logic [ChanW-1:0] chan_q, chan_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             idx_last;

  assign idx_last = (idx_q == IdxW'(DEPTH - 1));
  assign last_o   = idx_last && (chan_q == ChanW'(CHANNELS - 1));
  assign chan_o   = chan_q;
  assign idx_o    = idx_q;

  always_comb begin
    chan_d = chan_q;
    idx_d  = idx_q;
    if (clear_i) begin
      chan_d = '0;
      idx_d  = '0;
    end else if (step_i) begin
      if (idx_last) begin
        idx_d  = '0;
        chan_d = last_o ? '0 : chan_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chan_q <= '0;
      idx_q  <= '0;
    end else begin
      chan_q <= chan_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/vpi_var_model_bank.sv
// CHANNELS x DEPTH register bank sequenced through fill, external-modify wait and
// check phases. Optional WAIT timeout enabled by VPI_VAR_MODEL_TIMEOUT_EN.
module vpi_var_model_bank
  import vpi_var_model_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SEED     = 32'h10,
  parameter int unsigned TIMEOUT  = 1000,
  localparam int unsigned ChanW   = idx_width(CHANNELS),
  localparam int unsigned IdxW    = idx_width(DEPTH),
  localparam int unsigned ErrW    = $clog2(CHANNELS * DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ErrW-1:0]  err_count_o,
  output logic             timeout_o,
  output logic [ChanW-1:0] cur_chan_o,
  output logic [IdxW-1:0]  cur_idx_o
);

  // Externally modified by the VPI agent while the sequencer sits in WAIT.
  logic [WIDTH-1:0] mem_q [CHANNELS][DEPTH];

  state_e           state_q;
  logic             busy_q, done_q, pass_q;
  logic [ErrW-1:0]  err_q, err_d;
  logic [ChanW-1:0] cur_chan;
  logic [IdxW-1:0]  cur_idx;
  logic             walk_last, walk_clear, walk_step;
  logic [WIDTH-1:0] pat;
  logic             mismatch;

  assign walk_clear = ((state_q == StIdle) && start_i) || ((state_q == StWait) && ack_i);
  assign walk_step  = (state_q == StFill) || (state_q == StCheck);

  vpi_var_model_walker #(
    .DEPTH    (DEPTH),
    .CHANNELS (CHANNELS)
  ) u_walker (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (walk_clear),
    .step_i  (walk_step),
    .chan_o  (cur_chan),
    .idx_o   (cur_idx),
    .last_o  (walk_last)
  );

  assign pat      = WIDTH'(pattern(SEED, DEPTH, 32'(cur_chan), 32'(cur_idx)));
  assign mismatch = (mem_q[cur_chan][cur_idx] != (pat ^ mask_i));

  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

`ifdef VPI_VAR_MODEL_TIMEOUT_EN
  localparam int unsigned TmoW = idx_width(TIMEOUT);
  logic [TmoW-1:0] wait_cnt_q;
  logic            timeout_q;
  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_o      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[c][i] <= '0;
        end
      end
`ifdef VPI_VAR_MODEL_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StFill;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
`ifdef VPI_VAR_MODEL_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        StFill: begin
          mem_q[cur_chan][cur_idx] <= pat;
          if (walk_last) state_q <= StWait;
        end
        StWait: begin
          if (ack_i) begin
            state_q <= StCheck;
`ifdef VPI_VAR_MODEL_TIMEOUT_EN
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == TmoW'(TIMEOUT - 1)) begin
            state_q    <= StDone;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end
        StCheck: begin
          err_q <= err_d;
          if (walk_last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign cur_chan_o  = cur_chan;
  assign cur_idx_o   = cur_idx;

endmodule
